// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode instruction FIFO with flush; optional same-cycle bypass under IF_ID_QUEUE_BYPASS_EN
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [INST_W-1:0]          in_instruction,
    input  logic [ADDR_W-1:0]          in_pc_next,
    input  logic                       flush,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [INST_W-1:0]          out_instruction,
    output logic [ADDR_W-1:0]          out_pc_next,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INST_W-1:0] instMem [DEPTH];
    logic [ADDR_W-1:0] pcMem   [DEPTH];
    logic [PW-1:0]     wrPtr, rdPtr;
    logic              isEmpty, bypass, bypassTake, push, pop;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = ~rst & isEmpty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // Handshake decode; flush suppresses both push and pop, a bypassed word that decode takes is never stored
    always_comb begin
        isEmpty         = count == '0;
        in_ready        = count != CW'(DEPTH);
        bypassTake      = bypass & out_ready;
        push            = in_valid & in_ready & ~flush & ~bypassTake;
        pop             = ~isEmpty & out_ready & ~flush;
        out_valid       = ~isEmpty | bypass;
        out_instruction = ~isEmpty ? instMem[rdPtr] : bypass ? in_instruction : '0;
        out_pc_next     = ~isEmpty ? pcMem[rdPtr]   : bypass ? in_pc_next     : '0;
    end

    // Storage write; contents need no reset since pointers and count gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            instMem[wrPtr] <= in_instruction;
            pcMem[wrPtr]   <= in_pc_next;
        end
    end

    // Pointer and occupancy update; flush empties the queue ahead of any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= push ? wrPtr + PW'(1) : wrPtr;
            rdPtr <= pop ? rdPtr + PW'(1) : rdPtr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized and directed check of if_id_queue against a queue-based reference model
module tb_if_id_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_instruction = '0;
    logic [15:0] in_pc_next = '0;
    logic        flush = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_instruction;
    logic [15:0] out_pc_next;
    logic        out_ready = 1'b0;
    logic [2:0]  count;

    int nCmp = 0;
    int nErr = 0;
    logic [31:0] q[$];

    if_id_queue #(.DEPTH(DEPTH), .INST_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instruction(in_instruction),
        .in_pc_next(in_pc_next), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
        .out_instruction(out_instruction), .out_pc_next(out_pc_next), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check outputs against the model, then advance the model at posedge
    task automatic cycle(input bit iv, input logic [15:0] ins, input logic [15:0] pcn, input bit fl, input bit ordy);
        int  n;
        bit  byp;
        bit  doPush;
        @(negedge clk);
        in_valid = iv; in_instruction = ins; in_pc_next = pcn; flush = fl; out_ready = ordy;
        #1;
        n = q.size();
`ifdef IF_ID_QUEUE_BYPASS_EN
        byp = (n == 0) && iv && !fl;
`else
        byp = 1'b0;
`endif
        check("count", 32'(count), 32'(n));
        check("in_ready", 32'(in_ready), 32'(n != DEPTH));
        check("out_valid", 32'(out_valid), 32'(n != 0 || byp));
        check("out_instruction", 32'(out_instruction), n != 0 ? 32'(q[0][31:16]) : byp ? 32'(ins) : 32'h0);
        check("out_pc_next", 32'(out_pc_next), n != 0 ? 32'(q[0][15:0]) : byp ? 32'(pcn) : 32'h0);
        @(posedge clk);
        if (fl) q = {};
        else begin
            doPush = iv && n < DEPTH && !(byp && ordy);
            if (n != 0 && ordy) void'(q.pop_front());
            if (doPush) q.push_back({ins, pcn});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #1;
        check("reset_count", 32'(count), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hC000 + 16'(i), 16'h0100 + 16'(i), 1'b0, 1'b0);
        #1 check("pre_reset_count", 32'(count), 32'h3);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_reset_count", 32'(count), 32'h0);
        check("async_reset_out_valid", 32'(out_valid), 32'h0);
        check("async_reset_in_ready", 32'(in_ready), 32'h1);
        check("async_reset_out_instruction", 32'(out_instruction), 32'h0);
        check("async_reset_out_pc_next", 32'(out_pc_next), 32'h0);
        q = {};
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 5; i++) cycle(1'b1, 16'hA000 + 16'(i), 16'h0200 + 16'(i), 1'b0, 1'b0);
        #1;
        check("fill_count", 32'(count), 32'h4);
        check("fill_in_ready", 32'(in_ready), 32'h0);
        check("fill_head", 32'(out_instruction), 32'hA001);
        drain();

        for (int i = 0; i < 2; i++) cycle(1'b1, 16'hB000 + 16'(i), 16'h0300 + 16'(i), 1'b0, 1'b0);
        for (int i = 2; i < 8; i++) cycle(1'b1, 16'hB000 + 16'(i), 16'h0300 + 16'(i), 1'b0, 1'b1);
        #1;
        check("simul_count", 32'(count), 32'h2);
        check("simul_head", 32'(out_instruction), 32'hB006);
        drain();

        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hD000 + 16'(i), 16'h0400 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 16'h0499, 1'b1, 1'b1);
        #1;
        check("flush_count", 32'(count), 32'h0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        cycle(1'b1, 16'h1234, 16'h0500, 1'b0, 1'b0);
        #1 check("flush_next_head", 32'(out_instruction), 32'h1234);
        drain();

        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hE000 + 16'(i), 16'h0600 + 16'(i), 1'b0, 1'b0);
        cycle(1'b1, 16'hE0FF, 16'h06FF, 1'b0, 1'b1);
        #1;
        check("fullpop_count", 32'(count), 32'h3);
        check("fullpop_in_ready", 32'(in_ready), 32'h1);
        drain();

        cycle(1'b1, 16'hBEEF, 16'h0777, 1'b0, 1'b1);
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        check("bypass_count", 32'(count), 32'h0);
`else
        check("nobypass_head", 32'(out_instruction), 32'hBEEF);
`endif
        drain();

        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
